status_cond_unit: RTL and testbench

//  EXE-stage status register plus ARM condition evaluator, sitting beside the ALU.

---
 rtl/status_cond_unit_pkg.sv | 52 +++++
 rtl/status_cond_unit_cond_check.sv | 38 +++
 rtl/status_cond_unit.sv | 54 +++++
 tb/tb_status_cond_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/status_cond_unit_pkg.sv
// Shared ARM definitions: cond codes, NZCV bit positions, flag struct and
// EXE_CMD encodings used by the ALU, the ID stage and the EXE status unit.
package status_cond_unit_pkg;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // Named view of the flag nibble; field order matches the bit indices above
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // EXE_CMD encodings shared with the ALU
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_LDR = 4'b0010;
  localparam logic [3:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/status_cond_unit_cond_check.sv
// ARM condition evaluator: decides from a cond field and a flag nibble whether
// the instruction executes. Purely combinational so the ID stage can reuse it.
module cond_check
  import status_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  nzcv_t f;
  assign f = flags;

  // Full decode; NV and any unknown cond fall to pass=0
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = f.z;
      COND_NE: pass = ~f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = ~f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = ~f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = ~f.v;
      COND_HI: pass = f.c & ~f.z;
      COND_LS: pass = ~f.c | f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = ~f.z & (f.n == f.v);
      COND_LE: pass = f.z | (f.n != f.v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// EXE-stage status register with condition evaluation. Holds {N,Z,C,V},
// returns the registered carry to the ALU, and counts committed flag writes.
module status_cond_unit
  import status_cond_unit_pkg::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  input  logic             freeze,
  input  logic             flush,
  input  logic [3:0]       Status_bit,
  input  logic [3:0]       cond,
  output logic [3:0]       SR,
  output logic             C,
  output logic             cond_pass,
  output logic [CNT_W-1:0] upd_cnt
);

  logic       we;
  logic [3:0] flags;

  assign we = S & ~freeze & ~flush;

  // Flag register and saturating write counter; reset wins over a pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      SR      <= 4'b0000;
      upd_cnt <= '0;
    end else if (we) begin
      SR      <= Status_bit;
      upd_cnt <= (&upd_cnt) ? upd_cnt : upd_cnt + CNT_W'(1);
    end
  end

  // Carry back to the ALU is registered only: Status_bit depends on C,
  // so bypassing it here would close a combinational loop.
  assign C = SR[C_BIT];

  // Evaluation flags: optionally see this cycle's write with zero latency
  always_comb begin
    flags = SR;
    if (BYPASS != 0 && we) flags = Status_bit;
  end

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

endmodule

// File: tb/tb_status_cond_unit.sv
// Bench for status_cond_unit: three instances (bypass/16-bit counter,
// no-bypass/16-bit counter, bypass/4-bit counter) share one stimulus stream
// and are compared every cycle against a flag/counter model.
module tb_status_cond_unit;

  logic       clk = 1'b0;
  logic       rst, S, freeze, flush;
  logic [3:0] Status_bit, cond;

  logic [3:0]  sr_a, sr_b, sr_c;
  logic        c_a, c_b, c_c;
  logic        p_a, p_b, p_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  logic [3:0] m_sr  = 4'b0000;
  int         m_c16 = 0;
  int         m_c4  = 0;

  always #5 clk = ~clk;

  status_cond_unit #(.BYPASS(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .S(S), .freeze(freeze), .flush(flush),
    .Status_bit(Status_bit), .cond(cond),
    .SR(sr_a), .C(c_a), .cond_pass(p_a), .upd_cnt(cnt_a));

  status_cond_unit #(.BYPASS(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .S(S), .freeze(freeze), .flush(flush),
    .Status_bit(Status_bit), .cond(cond),
    .SR(sr_b), .C(c_b), .cond_pass(p_b), .upd_cnt(cnt_b));

  status_cond_unit #(.BYPASS(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .S(S), .freeze(freeze), .flush(flush),
    .Status_bit(Status_bit), .cond(cond),
    .SR(sr_c), .C(c_c), .cond_pass(p_c), .upd_cnt(cnt_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule: pairs of codes share a base test, odd code is its inverse;
  // the 111x pair is always/never.
  function automatic bit exp_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // model update on the clock edge
  always @(posedge clk) begin
    if (rst) begin
      m_sr  <= 4'b0000;
      m_c16 <= 0;
      m_c4  <= 0;
    end else if (S && !freeze && !flush) begin
      m_sr  <= Status_bit;
      m_c16 <= (m_c16 < 65535) ? m_c16 + 1 : 65535;
      m_c4  <= (m_c4 < 15) ? m_c4 + 1 : 15;
    end
  end

  // per-cycle compare of all instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit         wr;
      logic [3:0] fb;
      wr = S && !freeze && !flush;
      fb = wr ? Status_bit : m_sr;
      chk("sr_a", sr_a, m_sr);
      chk("sr_b", sr_b, m_sr);
      chk("sr_c", sr_c, m_sr);
      chk("c_a", c_a, m_sr[1]);
      chk("c_b", c_b, m_sr[1]);
      chk("c_c", c_c, m_sr[1]);
      chk("pass_a", p_a, exp_pass(cond, fb));
      chk("pass_b", p_b, exp_pass(cond, m_sr));
      chk("pass_c", p_c, exp_pass(cond, fb));
      chk("cnt_a", cnt_a, m_c16);
      chk("cnt_b", cnt_b, m_c16);
      chk("cnt_c", cnt_c, m_c4);
    end
  end

  task automatic step(input bit r, input bit s, input bit fz, input bit fl,
                      input logic [3:0] sb, input logic [3:0] c);
    @(posedge clk);
    #1;
    rst = r; S = s; freeze = fz; flush = fl; Status_bit = sb; cond = c;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; S = 1'b0; freeze = 1'b0; flush = 1'b0;
    Status_bit = 4'b0000; cond = 4'b0001;

    // reset for two clocks
    @(posedge clk);
    step(0, 0, 0, 0, 4'b0000, 4'b0001);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sr", sr_a, 4'b0000);
    chk("rst_c", c_a, 1'b0);
    chk("rst_cnt", cnt_a, 16'd0);
    chk("rst_ne", p_a, 1'b1);

    // single write, then HI / LS on registered flags
    step(0, 1, 0, 0, 4'b0110, 4'b1000);
    step(0, 0, 0, 0, 4'b0000, 4'b1000);
    @(negedge clk);
    chk("wr_sr", sr_a, 4'b0110);
    chk("wr_c", c_a, 1'b1);
    chk("wr_cnt", cnt_a, 16'd1);
    chk("wr_hi", p_a, 1'b0);
    step(0, 0, 0, 0, 4'b0000, 4'b1001);
    @(negedge clk);
    chk("wr_ls", p_a, 1'b1);

    // blocked writes: freeze, flush, both
    step(0, 1, 1, 0, 4'b1001, 4'b1110);
    step(0, 1, 0, 1, 4'b1001, 4'b1110);
    step(0, 1, 1, 1, 4'b1001, 4'b1110);
    step(0, 0, 0, 0, 4'b1001, 4'b1110);
    @(negedge clk);
    chk("blk_sr", sr_a, 4'b0110);
    chk("blk_cnt", cnt_a, 16'd1);

    // bypass: SR=0000, same-cycle write of Z
    step(0, 1, 0, 0, 4'b0000, 4'b0000);
    step(0, 1, 0, 0, 4'b0100, 4'b0000);
    @(negedge clk);
    chk("byp_eq", p_a, 1'b1);
    chk("nobyp_eq", p_b, 1'b0);
    chk("byp_c", c_a, 1'b0);
    chk("nobyp_c", c_b, 1'b0);

    // every flag nibble against every cond code
    for (int f = 0; f < 16; f++) begin
      step(0, 1, 0, 0, 4'(f), 4'b1110);
      for (int c = 0; c < 16; c++) begin
        step(0, 0, 0, 0, 4'(f), 4'(c));
        @(negedge clk);
        if (c == 15) chk("nv", p_a, 1'b0);
        if (f == 4'b1000 && c == 10) chk("ge_n1v0", p_a, 1'b0);
        if (f == 4'b1000 && c == 11) chk("lt_n1v0", p_a, 1'b1);
        if (f == 4'b1001 && c == 12) chk("gt_n1v1", p_a, 1'b1);
      end
    end

    // counter saturation from a fresh reset
    step(1, 0, 0, 0, 4'b0000, 4'b1110);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 4'(i), 4'b1110);
    step(0, 0, 0, 0, 4'b0000, 4'b1110);
    @(negedge clk);
    chk("sat4", cnt_c, 16'd15);
    chk("cnt20", cnt_a, 16'd20);

    // reset coincident with a write: write is dropped
    step(1, 1, 0, 0, 4'b1111, 4'b0000);
    step(0, 0, 0, 0, 4'b1111, 4'b0000);
    @(negedge clk);
    chk("rstw_sr", sr_a, 4'b0000);
    chk("rstw_cnt", cnt_a, 16'd0);
    chk("rstw_cnt4", cnt_c, 16'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(31) == 0), ($urandom_range(3) != 0),
           ($urandom_range(4) == 0), ($urandom_range(4) == 0),
           4'($urandom), 4'($urandom));
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
